// File: rtl/swd_pkg.sv
// Shared definitions for the SWD transfer controller.
// Holds the controller state encoding, the ACK response codes and the bit
// positions of the fields in the 8-bit request header. It also provides a
// helper that assembles the header with its parity bit.
package swd_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LRST,
    ST_HDR,
    ST_TRN1,
    ST_ACK,
    ST_TRN2,
    ST_RDATA,
    ST_RPAR,
    ST_WDATA,
    ST_WPAR,
    ST_TAIL,
    ST_RESP
  } swd_state_e;

  localparam logic [2:0] ACK_OK    = 3'b001;
  localparam logic [2:0] ACK_WAIT  = 3'b010;
  localparam logic [2:0] ACK_FAULT = 3'b100;

  // Header bit positions, bit 0 goes out first on the wire.
  localparam int HDR_START = 0;
  localparam int HDR_APNDP = 1;
  localparam int HDR_RNW   = 2;
  localparam int HDR_A2    = 3;
  localparam int HDR_A3    = 4;
  localparam int HDR_PAR   = 5;
  localparam int HDR_STOP  = 6;
  localparam int HDR_PARK  = 7;

  function automatic logic [7:0] swd_header(input logic apndp, input logic rnw,
                                            input logic [1:0] a);
    logic [7:0] h;
    h            = '0;
    h[HDR_START] = 1'b1;
    h[HDR_APNDP] = apndp;
    h[HDR_RNW]   = rnw;
    h[HDR_A2]    = a[0];
    h[HDR_A3]    = a[1];
    h[HDR_PAR]   = apndp ^ rnw ^ a[0] ^ a[1];
    h[HDR_STOP]  = 1'b0;
    h[HDR_PARK]  = 1'b1;
    return h;
  endfunction

endpackage

// File: rtl/swd_xfer_ctrl_if.sv
// Command/response handshake bundle of the SWD transfer controller.
//   cmd_*  : command offer (valid/ready) with operation, AP/DP, direction,
//            address A[3:2] and write data
//   rsp_*  : response hold (valid/ready) with ACK, read data, parity error
// master : the agent issuing commands; slave : the controller.
interface swd_xfer_ctrl_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_op;
  logic        cmd_apndp;
  logic        cmd_rnw;
  logic [1:0]  cmd_a;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [2:0]  rsp_ack;
  logic [31:0] rsp_rdata;
  logic        rsp_perr;

  modport master (
    output cmd_valid, cmd_op, cmd_apndp, cmd_rnw, cmd_a, cmd_wdata, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_ack, rsp_rdata, rsp_perr
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_apndp, cmd_rnw, cmd_a, cmd_wdata, rsp_ready,
    output cmd_ready, rsp_valid, rsp_ack, rsp_rdata, rsp_perr
  );
endinterface

// File: rtl/swd_sck_gen.sv
// SWD serial clock generator.
//   clk, rst_n : system clock, synchronous active-low reset
//   en         : run the clock; when low sck parks low and the divider clears
//   sck        : serial clock, half-period CLK_DIV+1 clk cycles
//   rise, fall : one-cycle strobes, high in the clk cycle whose edge moves sck
module swd_sck_gen #(
  parameter int CLK_DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic sck,
  output logic rise,
  output logic fall
);

  localparam int CW = (CLK_DIV < 1) ? 1 : $clog2(CLK_DIV + 1);

  logic [CW-1:0] div_cnt;
  logic          tick;

  assign tick = en && (div_cnt == CW'(CLK_DIV));
  assign rise = tick && !sck;
  assign fall = tick && sck;

  always_ff @(posedge clk) begin
    if (!rst_n || !en) begin
      div_cnt <= '0;
      sck     <= 1'b0;
    end else if (tick) begin
      div_cnt <= '0;
      sck     <= !sck;
    end else begin
      div_cnt <= div_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/swd_xfer_ctrl.sv
// SWD transfer controller: runs one SWD read/write transfer or line reset
// per accepted command and holds the result until it is consumed.
//   clk, rst_n      : system clock, synchronous active-low reset
//   bus (slave)     : cmd_* command handshake, rsp_* response handshake
//   sck, mosi, miso : serial frontend clock and data
//   fe_rst_n        : frontend framing enable (low = raw drive)
//   fe_rnw          : frontend direction hint
//   busy            : controller not idle
//
// state    | meaning
// IDLE     | waiting for a command
// LRST     | line reset: LRST_ONES ones then two zeros
// HDR      | 8-bit request header
// TRN1     | turnaround before ACK
// ACK      | 3 ACK bits sampled from miso
// TRN2     | turnaround after ACK (write/fault) or after read parity
// RDATA    | 32 read data bits sampled
// RPAR     | read parity sampled and checked
// WDATA    | 32 write data bits driven
// WPAR     | write parity driven
// TAIL     | IDLE_CYCLES zero bits after the transfer
// RESP     | response held until consumed
module swd_xfer_ctrl #(
  parameter int CLK_DIV     = 1,
  parameter int IDLE_CYCLES = 8,
  parameter int LRST_ONES   = 56
) (
  input  logic            clk,
  input  logic            rst_n,
  swd_xfer_ctrl_if.slave  bus,
  output logic            sck,
  output logic            mosi,
  input  logic            miso,
  output logic            fe_rst_n,
  output logic            fe_rnw,
  output logic            busy
);
  import swd_pkg::*;

  localparam logic [5:0] TAIL_LAST = 6'(IDLE_CYCLES - 1);
  localparam logic [5:0] LRST_N    = 6'(LRST_ONES);
  localparam logic [5:0] LRST_LAST = 6'(LRST_ONES + 1);

  swd_state_e  state, state_nxt;
  logic [5:0]  bit_cnt, last_idx;
  logic [31:0] shreg;
  logic        apndp_q, rnw_q;
  logic [1:0]  a_q;
  logic [2:0]  ack_q;
  logic [31:0] rdata_q;
  logic        perr_q;
  logic [7:0]  hdr;
  logic        rise, fall, sck_en, last_bit, accept;

  assign hdr    = swd_header(apndp_q, rnw_q, a_q);
  assign sck_en = (state != ST_IDLE) && (state != ST_RESP);
  assign accept = bus.cmd_valid && bus.cmd_ready;

  swd_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (sck_en),
    .sck  (sck),
    .rise (rise),
    .fall (fall)
  );

  always_comb begin
    last_idx = 6'd0;
    case (state)
      ST_LRST:            last_idx = LRST_LAST;
      ST_HDR:             last_idx = 6'd7;
      ST_ACK:             last_idx = 6'd2;
      ST_RDATA, ST_WDATA: last_idx = 6'd31;
      ST_TAIL:            last_idx = TAIL_LAST;
      default:            last_idx = 6'd0;
    endcase
  end

  // A bit period ends on the sck falling edge, which is also where mosi moves.
  assign last_bit = fall && (bit_cnt == last_idx);

  always_comb begin
    state_nxt = state;
    mosi      = 1'b0;
    case (state)
      ST_IDLE:  if (accept) state_nxt = bus.cmd_op ? ST_LRST : ST_HDR;
      ST_LRST: begin
        mosi = (bit_cnt < LRST_N);
        if (last_bit) state_nxt = ST_RESP;
      end
      ST_HDR: begin
        mosi = hdr[bit_cnt[2:0]];
        if (last_bit) state_nxt = ST_TRN1;
      end
      ST_TRN1:  if (last_bit) state_nxt = ST_ACK;
      // The third ACK bit was captured on the preceding rise, so ack_q is complete here.
      ST_ACK:   if (last_bit) state_nxt = (ack_q == ACK_OK && rnw_q) ? ST_RDATA : ST_TRN2;
      ST_TRN2: begin
        if (last_bit) begin
          if (ack_q != ACK_OK) state_nxt = ST_RESP;
          else if (rnw_q)      state_nxt = ST_TAIL;
          else                 state_nxt = ST_WDATA;
        end
      end
      ST_RDATA: if (last_bit) state_nxt = ST_RPAR;
      ST_RPAR:  if (last_bit) state_nxt = ST_TRN2;
      ST_WDATA: begin
        mosi = shreg[0];
        if (last_bit) state_nxt = ST_WPAR;
      end
      // shreg has rotated a full turn during WDATA, so it holds the word again.
      ST_WPAR: begin
        mosi = ^shreg;
        if (last_bit) state_nxt = ST_TAIL;
      end
      ST_TAIL:  if (last_bit) state_nxt = ST_RESP;
      ST_RESP:  if (bus.rsp_ready) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      apndp_q <= 1'b0;
      rnw_q   <= 1'b0;
      a_q     <= '0;
      ack_q   <= '0;
      rdata_q <= '0;
      perr_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) bit_cnt <= '0;
      else if (fall)          bit_cnt <= bit_cnt + 6'd1;

      if (accept) begin
        apndp_q <= bus.cmd_apndp;
        rnw_q   <= bus.cmd_rnw;
        a_q     <= bus.cmd_a;
        shreg   <= bus.cmd_wdata;
        ack_q   <= '0;
        rdata_q <= '0;
        perr_q  <= 1'b0;
      end

      if (rise) begin
        case (state)
          ST_ACK:   ack_q[bit_cnt[1:0]] <= miso;
          ST_RDATA: shreg <= {miso, shreg[31:1]};
          ST_RPAR: begin
            rdata_q <= shreg;
            perr_q  <= miso ^ (^shreg);
          end
          default: ;
        endcase
      end

      if (fall && state == ST_WDATA) shreg <= {shreg[0], shreg[31:1]};
    end
  end

  assign busy          = (state != ST_IDLE);
  assign fe_rst_n      = sck_en && (state != ST_LRST);
  assign fe_rnw        = fe_rst_n ? rnw_q : 1'b1;
  assign bus.rsp_valid = (state == ST_RESP);
  assign bus.cmd_ready = (state == ST_IDLE) && !bus.rsp_valid;
  assign bus.rsp_ack   = ack_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_perr  = perr_q;

endmodule

// File: tb/tb_swd_xfer_ctrl.sv
module tb_swd_xfer_ctrl;
  import swd_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sck, mosi, fe_rst_n, fe_rnw, busy;
  logic miso = 1'b0;

  swd_xfer_ctrl_if bus();

  swd_xfer_ctrl #(.CLK_DIV(1), .IDLE_CYCLES(8), .LRST_ONES(56)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .sck     (sck),
    .mosi    (mosi),
    .miso    (miso),
    .fe_rst_n(fe_rst_n),
    .fe_rnw  (fe_rnw),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int timeouts = 0;
  int cyc;
  logic [63:0] mo;
  logic fe_and, fe_or, rnw_or;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] out_pack();
    return {sck, mosi, fe_rst_n, fe_rnw, bus.cmd_ready, bus.rsp_valid, busy,
            bus.rsp_ack, bus.rsp_perr};
  endfunction

  task automatic clr_mon();
    fe_and = 1'b1;
    fe_or  = 1'b0;
    rnw_or = 1'b0;
  endtask

  // Runs n bit periods: drives miso bit i during bit i, records mosi at sck high.
  task automatic run_bits(input int n, input logic [63:0] mi, output logic [63:0] bits);
    int t;
    bits = '0;
    for (int i = 0; i < n; i++) begin
      miso = mi[i];
      t = 0;
      while (sck !== 1'b1 && t < 16) begin @(negedge clk); t++; end
      if (t >= 16) timeouts++;
      bits[i] = mosi;
      fe_and  = fe_and & fe_rst_n;
      fe_or   = fe_or | fe_rst_n;
      rnw_or  = rnw_or | fe_rnw;
      t = 0;
      while (sck !== 1'b0 && t < 16) begin @(negedge clk); t++; end
      if (t >= 16) timeouts++;
    end
    miso = 1'b0;
  endtask

  task automatic issue(input logic op, input logic apndp, input logic rnw,
                       input logic [1:0] a, input logic [31:0] wd);
    int w = 0;
    while (bus.cmd_ready !== 1'b1 && w < 20) begin @(negedge clk); w++; end
    if (w >= 20) timeouts++;
    bus.cmd_op    = op;
    bus.cmd_apndp = apndp;
    bus.cmd_rnw   = rnw;
    bus.cmd_a     = a;
    bus.cmd_wdata = wd;
    bus.cmd_valid = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    check("accept_busy", 64'(busy), 64'd1);
  endtask

  task automatic wait_rsp(output int c);
    c = 0;
    while (bus.rsp_valid !== 1'b1 && c < 40) begin @(negedge clk); c++; end
    if (c >= 40) timeouts++;
  endtask

  task automatic finish_rsp();
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check("resp_done_idle", 64'({busy, bus.rsp_valid}), 64'd0);
  endtask

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_op = 1'b0; bus.cmd_apndp = 1'b0; bus.cmd_rnw = 1'b0;
    bus.cmd_a = 2'b00; bus.cmd_wdata = '0; bus.rsp_ready = 1'b0;
    clr_mon();
    repeat (3) @(negedge clk);
    check("reset_outputs", 64'(out_pack()), 64'h0C0);
    check("reset_rdata", 64'(bus.rsp_rdata), 64'd0);

    // DP read addr 0, first command in the first cycle out of reset
    rst_n = 1'b1;
    issue(1'b0, 1'b0, 1'b1, 2'b00, 32'h0);
    clr_mon();
    run_bits(8, 64'h0, mo);
    check("rd_hdr", mo, 64'hA5);
    check("rd_cmd_ready_busy", 64'(bus.cmd_ready), 64'd0);
    run_bits(1, 64'h0, mo);
    run_bits(3, 64'h1, mo);
    run_bits(32, 64'h2BA01477, mo);
    check("rd_mosi_low_in_data", mo, 64'h0);
    run_bits(1, 64'h0, mo);
    run_bits(1, 64'h0, mo);
    run_bits(8, 64'h0, mo);
    check("rd_tail_zero", mo, 64'h0);
    check("rd_framed_rnw", 64'({fe_and, rnw_or}), 64'h3);
    wait_rsp(cyc);
    repeat (3) @(negedge clk);
    check("rd_rsp_held", 64'(bus.rsp_valid), 64'd1);
    check("rd_ack", 64'(bus.rsp_ack), 64'(ACK_OK));
    check("rd_data", 64'(bus.rsp_rdata), 64'h2BA01477);
    check("rd_perr", 64'(bus.rsp_perr), 64'd0);
    check("rd_fe_in_resp", 64'({fe_rst_n, fe_rnw}), 64'h1);
    finish_rsp();

    // AP write A=01
    issue(1'b0, 1'b1, 1'b0, 2'b01, 32'hA5A5A5A5);
    clr_mon();
    run_bits(8, 64'h0, mo);
    check("wr_hdr", mo, 64'h8B);
    run_bits(1, 64'h0, mo);
    run_bits(3, 64'h1, mo);
    run_bits(1, 64'h0, mo);
    run_bits(32, 64'h0, mo);
    check("wr_data", mo, 64'hA5A5A5A5);
    run_bits(1, 64'h0, mo);
    check("wr_par", mo, 64'h0);
    run_bits(8, 64'h0, mo);
    check("wr_tail_zero", mo, 64'h0);
    check("wr_framed_rnw", 64'({fe_and, rnw_or}), 64'h2);
    wait_rsp(cyc);
    check("wr_ack", 64'(bus.rsp_ack), 64'(ACK_OK));
    finish_rsp();

    // AP read A=10 answered with WAIT: no data phase
    issue(1'b0, 1'b1, 1'b1, 2'b10, 32'h0);
    run_bits(8, 64'h0, mo);
    check("wait_hdr", mo, 64'hB7);
    run_bits(1, 64'h0, mo);
    run_bits(3, 64'h2, mo);
    wait_rsp(cyc);
    check("wait_rsp_latency", 64'(cyc), 64'd4);
    check("wait_ack", 64'(bus.rsp_ack), 64'(ACK_WAIT));
    check("wait_rdata", 64'(bus.rsp_rdata), 64'd0);
    finish_rsp();

    // DP read A=11 with a corrupted parity bit
    issue(1'b0, 1'b0, 1'b1, 2'b11, 32'h0);
    run_bits(8, 64'h0, mo);
    check("perr_hdr", mo, 64'hBD);
    run_bits(1, 64'h0, mo);
    run_bits(3, 64'h1, mo);
    run_bits(32, 64'h12345678, mo);
    run_bits(1, 64'h0, mo);
    run_bits(1, 64'h0, mo);
    run_bits(8, 64'h0, mo);
    wait_rsp(cyc);
    check("perr_flag", 64'(bus.rsp_perr), 64'd1);
    check("perr_data", 64'(bus.rsp_rdata), 64'h12345678);
    finish_rsp();

    // Line reset
    issue(1'b1, 1'b0, 1'b0, 2'b00, 32'h0);
    clr_mon();
    run_bits(58, 64'h0, mo);
    check("lrst_bits", mo, 64'h00FF_FFFF_FFFF_FFFF);
    check("lrst_fe_low", 64'(fe_or), 64'd0);
    wait_rsp(cyc);
    check("lrst_rsp_now", 64'(cyc), 64'd0);
    check("lrst_ack", 64'(bus.rsp_ack), 64'd0);
    finish_rsp();

    // Reset during WDATA bit 10, then a normal write
    issue(1'b0, 1'b0, 1'b0, 2'b10, 32'hDEADBEEF);
    run_bits(8, 64'h0, mo);
    check("mid_hdr", mo, 64'hB1);
    run_bits(1, 64'h0, mo);
    run_bits(3, 64'h1, mo);
    run_bits(1, 64'h0, mo);
    run_bits(10, 64'h0, mo);
    check("mid_data_lo", mo, 64'h2EF);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_reset_outputs", 64'(out_pack()), 64'h0C0);
    check("mid_reset_rdata", 64'(bus.rsp_rdata), 64'd0);
    rst_n = 1'b1;
    issue(1'b0, 1'b1, 1'b0, 2'b11, 32'h00000001);
    clr_mon();
    run_bits(8, 64'h0, mo);
    check("post_hdr", mo, 64'hBB);
    run_bits(1, 64'h0, mo);
    run_bits(3, 64'h1, mo);
    run_bits(1, 64'h0, mo);
    run_bits(32, 64'h0, mo);
    check("post_data", mo, 64'h1);
    run_bits(1, 64'h0, mo);
    check("post_par", mo, 64'h1);
    run_bits(8, 64'h0, mo);
    wait_rsp(cyc);
    check("post_ack", 64'(bus.rsp_ack), 64'(ACK_OK));
    finish_rsp();

    check("no_timeouts", 64'(timeouts), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/swd_xfer_ctrl.md
SWD_XFER_CTRL -- requirements
Module: swd_xfer_ctrl

Interface
REQ-001 Parameter CLK_DIV, default 1; sck half-period is CLK_DIV+1 clk cycles.
REQ-002 Parameter IDLE_CYCLES, default 8; count of trailing low sck cycles after each transfer.
REQ-003 Parameter LRST_ONES, default 56; count of high bits in a line reset.
REQ-004 Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when both cmd_valid and cmd_ready are high.
- cmd_op  in  1  0 = transfer, 1 = line reset.
- cmd_apndp  in  1  1 = AP access, 0 = DP access.
- cmd_rnw  in  1  1 = read, 0 = write.
- cmd_a  in  2  register address A[3:2].
- cmd_wdata  in  32  write data.
- rsp_valid  out  1  response held.
- rsp_ready  in  1  response consumed.
- rsp_ack  out  3  ACK bits, bit0 first on the wire.
- rsp_rdata  out  32  read data.
- rsp_perr  out  1  read parity mismatch.
- sck  out  1  frontend clock.
- mosi  out  1  frontend data to target.
- miso  in  1  frontend data from target.
- fe_rst_n  out  1  frontend frame enable; low = raw drive.
- fe_rnw  out  1  frontend direction hint.
- busy  out  1  high whenever state is not IDLE.

Function
REQ-005 States: IDLE, LRST, HDR, TRN1, ACK, TRN2, RDATA, RPAR, WDATA, WPAR, TAIL, RESP.
REQ-006 cmd_ready is high only in IDLE with rsp_valid low; acceptance captures all cmd_* fields.
REQ-007 One bit period is one full sck cycle; sck idles low; mosi updates on sck falling edge; miso is sampled in the clk cycle that raises sck.
REQ-008 All fields go out LSB first.
REQ-009 Header is 8 bits: 1, APnDP, RnW, A2, A3, parity, 0, 1. Parity is the XOR of APnDP, RnW, A2 and A3.
REQ-010 Transfer sequence:
- HDR 8 bits, then TRN1 1 bit, then ACK 3 bits captured into rsp_ack.
- ACK = 3'b001 and read: RDATA 32, RPAR 1, TRN2 1, TAIL.
- ACK = 3'b001 and write: TRN2 1, WDATA 32, WPAR 1, TAIL.
- Any other ACK: TRN2 1, then RESP, with no data phase and no TAIL.
REQ-011 In TAIL, mosi is 0 for IDLE_CYCLES bit periods, then the state moves to RESP.
REQ-012 Write parity is the XOR of the 32 data bits; rsp_perr is 1 when the received read parity does not equal the XOR of rsp_rdata.
REQ-013 Line reset: LRST drives LRST_ONES bits of 1, then 2 bits of 0, then RESP with rsp_ack = 3'b000.
REQ-014 fe_rst_n:
- low in IDLE, LRST and RESP;
- goes high in the clk cycle that enters HDR;
- stays high through TAIL.
REQ-015 fe_rnw equals the captured cmd_rnw while fe_rst_n is high, and is 1 otherwise.
REQ-016 rsp_valid goes high on entry to RESP and holds rsp_* stable until rsp_valid and rsp_ready are both high; the state then returns to IDLE in the next cycle.
REQ-017 rsp_ready high before rsp_valid has no effect; cmd_valid is ignored while busy.
REQ-018 mosi is a don't-care during TRN, ACK and RDATA, and is driven 0.

Reset
REQ-019 rst_n low at any clk edge, mid-transfer included, forces the following in the next cycle:
- state = IDLE, sck = 0, mosi = 0;
- fe_rst_n = 0, fe_rnw = 1;
- cmd_ready = 1, rsp_valid = 0, busy = 0;
- rsp_ack = 0, rsp_rdata = 0, rsp_perr = 0, and all counters = 0.
REQ-020 After reset is released, the first command is accepted in the first cycle that rst_n is high.

Structure
REQ-021 Shared package swd_pkg holds the state enum, ACK encodings (OK = 3'b001, WAIT = 3'b010, FAULT = 3'b100) and the header field bit positions.
REQ-022 Sub-module swd_sck_gen produces sck and one-cycle rise and fall strobes from CLK_DIV; all remaining logic is a single FSM plus a 6-bit bit counter and a 32-bit shift register.

Verification
REQ-023 DP read, addr 0, miso model returns ACK 001 and data 0x2BA01477 with parity 0 -> header wire bits 1,0,1,0,0,1,0,1; rsp_rdata = 0x2BA01477; rsp_perr = 0.
REQ-024 AP write, A = 2'b01, data 0xA5A5A5A5 -> header 1,1,0,1,0,0,0,1; after TRN2 mosi carries the 32 data bits LSB first, then parity 0; fe_rnw = 0 while framed.
REQ-025 Read with ACK 010 -> no data phase; rsp_ack = 3'b010; rsp_valid rises 1 bit period after the last ACK bit.
REQ-026 Read with a corrupted parity bit -> rsp_perr = 1 with the data still returned.
REQ-027 Line reset with LRST_ONES = 56 -> 56 high bits then 2 low bits; fe_rst_n low throughout; rsp_ack = 0.
REQ-028 rst_n pulsed low during WDATA bit 10 -> next cycle all outputs at reset values; the next command completes normally.
